// File: rtl/mult_err_monitor.sv
// Windowed error statistics for an approximate multiplier: sum/max of |A*B-R| and mismatch count.
// Optional ERR_SQ_EN macro adds a squared-error accumulator on sum_sq.
module mult_err_monitor #(
   parameter int WIDTH = 8,
   parameter int LOG_N = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         A,
   input  logic [WIDTH-1:0]         B,
   input  logic [2*WIDTH-1:0]       R,
   output logic                     busy,
   output logic                     done,
   output logic [2*WIDTH+LOG_N-1:0] sum_ed,
   output logic [2*WIDTH-1:0]       max_ed,
   output logic [LOG_N:0]           err_cnt,
   output logic [4*WIDTH+LOG_N-1:0] sum_sq
);
   // state | meaning
   // IDLE  | waiting for start, no samples accepted
   // RUN   | accepting samples until N have been taken
   // DRAIN | pipeline flushing the last samples into the statistics
   // DONE  | results valid and held until the next start
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int PW = 2 * WIDTH;
   localparam logic [LOG_N:0] N_LAST = {1'b0, {LOG_N{1'b1}}};

   state_t           state_q, state_d;
   logic [LOG_N:0]   acc_cnt_q, acc_cnt_d;
   logic [1:0]       drain_q, drain_d;
   logic             accept, clear;

   logic [PW-1:0]    prod, ed;
   logic [PW-1:0]    p1_q, r1_q, ed2_q;
   logic             v1_q, v2_q, ne2_q;

   logic [PW+LOG_N-1:0] sum_ed_q, sum_ed_d;
   logic [PW-1:0]       max_ed_q, max_ed_d;
   logic [LOG_N:0]      err_cnt_q, err_cnt_d;

   always_comb begin
      state_d   = state_q;
      acc_cnt_d = acc_cnt_q;
      drain_d   = drain_q;
      in_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      clear     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               acc_cnt_d = '0;
               clear     = 1'b1;
            end
         end
         RUN: begin
            busy     = 1'b1;
            in_ready = (acc_cnt_q <= N_LAST);
            if (in_valid && in_ready) begin
               acc_cnt_d = acc_cnt_q + 1'b1;
               if (acc_cnt_q == N_LAST) begin
                  state_d = DRAIN;
                  drain_d = 2'd0;
               end
            end
         end
         DRAIN: begin
            busy = 1'b1;
            // Last sample lands in the statistics one edge before DONE is entered.
            if (drain_q == 2'd2) state_d = DONE;
            else                 drain_d = drain_q + 2'd1;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_d   = RUN;
               acc_cnt_d = '0;
               clear     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;
   assign prod   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
   assign ed     = (p1_q >= r1_q) ? (p1_q - r1_q) : (r1_q - p1_q);

   always_comb begin
      sum_ed_d  = sum_ed_q;
      max_ed_d  = max_ed_q;
      err_cnt_d = err_cnt_q;
      if (clear) begin
         sum_ed_d  = '0;
         max_ed_d  = '0;
         err_cnt_d = '0;
      end else if (v2_q) begin
         sum_ed_d  = sum_ed_q + {{LOG_N{1'b0}}, ed2_q};
         max_ed_d  = (ed2_q > max_ed_q) ? ed2_q : max_ed_q;
         err_cnt_d = err_cnt_q + {{LOG_N{1'b0}}, ne2_q};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_cnt_q <= '0;
         drain_q   <= '0;
         p1_q      <= '0;
         r1_q      <= '0;
         v1_q      <= 1'b0;
         ed2_q     <= '0;
         ne2_q     <= 1'b0;
         v2_q      <= 1'b0;
         sum_ed_q  <= '0;
         max_ed_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_cnt_q <= acc_cnt_d;
         drain_q   <= drain_d;
         v1_q      <= accept;
         if (accept) begin
            p1_q <= prod;
            r1_q <= R;
         end
         v2_q <= v1_q;
         if (v1_q) begin
            ed2_q <= ed;
            ne2_q <= (p1_q != r1_q);
         end
         sum_ed_q  <= sum_ed_d;
         max_ed_q  <= max_ed_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign sum_ed  = sum_ed_q;
   assign max_ed  = max_ed_q;
   assign err_cnt = err_cnt_q;

`ifdef ERR_SQ_EN
   logic [2*PW-1:0]       sq, sq2_q;
   logic [2*PW+LOG_N-1:0] sum_sq_q;

   assign sq = {{PW{1'b0}}, ed} * {{PW{1'b0}}, ed};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq2_q    <= '0;
         sum_sq_q <= '0;
      end else begin
         if (v1_q) sq2_q <= sq;
         if (clear)     sum_sq_q <= '0;
         else if (v2_q) sum_sq_q <= sum_sq_q + {{LOG_N{1'b0}}, sq2_q};
      end
   end

   assign sum_sq = sum_sq_q;
`else
   assign sum_sq = '0;
`endif

endmodule

// File: tb/tb_mult_err_monitor.sv
// Directed bench for mult_err_monitor with a 4-sample window (LOG_N = 2).
module tb_mult_err_monitor;
   localparam int W  = 8;
   localparam int LN = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [W-1:0]      A = '0, B = '0;
   logic [2*W-1:0]    R = '0;
   logic              busy, done;
   logic [2*W+LN-1:0] sum_ed;
   logic [2*W-1:0]    max_ed;
   logic [LN:0]       err_cnt;
   logic [4*W+LN-1:0] sum_sq;

   int checks = 0;
   int failures = 0;

   logic [W-1:0]   va [4];
   logic [W-1:0]   vb [4];
   logic [2*W-1:0] vr [4];

   mult_err_monitor #(.WIDTH(W), .LOG_N(LN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .A(A), .B(B), .R(R), .busy(busy), .done(done),
      .sum_ed(sum_ed), .max_ed(max_ed), .err_cnt(err_cnt), .sum_sq(sum_sq)
   );

   always #5 clk = ~clk;

   // Pulses start (optionally with a junk sample that must be dropped), then sends va/vb/vr back to back.
   // Returns at the negedge after the edge that accepted the 4th sample.
   task automatic send4(input logic junk);
      @(negedge clk);
      start = 1'b1; in_valid = junk; A = 8'd255; B = 8'd255; R = 16'd0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         A = va[i]; B = vb[i]; R = vr[i]; in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      #2;
      checks++; if ({in_ready, busy, done} !== 3'b000) begin failures++; $display("FAIL reset_ctrl in_ready/busy/done=%b required 000", {in_ready, busy, done}); end
      checks++; if (sum_ed !== '0 || max_ed !== '0 || err_cnt !== '0 || sum_sq !== '0) begin failures++; $display("FAIL reset_stats sum=%0d max=%0d cnt=%0d sq=%0d required 0", sum_ed, max_ed, err_cnt, sum_sq); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++; if ({in_ready, busy, done} !== 3'b000) begin failures++; $display("FAIL idle_ctrl in_ready/busy/done=%b required 000", {in_ready, busy, done}); end
   endtask

   task automatic test_exact;
      int cyc;
      logic [W-1:0]   ta [4] = '{8'd3, 8'd7, 8'd0, 8'd255};
      logic [W-1:0]   tb [4] = '{8'd5, 8'd9, 8'd0, 8'd1};
      logic [2*W-1:0] tr [4] = '{16'd15, 16'd63, 16'd0, 16'd255};
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL exact_start in_ready=%b busy=%b required 1 1", in_ready, busy); end
      for (int i = 0; i < 4; i++) begin
         A = ta[i]; B = tb[i]; R = tr[i]; in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL exact_drain in_ready=%b busy=%b done=%b required 0 1 0", in_ready, busy, done); end
      @(negedge clk); @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL exact_early_done done=%b required 0 at e+2", done); end
      @(negedge clk);
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL exact_done done=%b busy=%b required 1 0 at e+3", done, busy); end
      checks++; if (sum_ed !== 0 || max_ed !== 0 || err_cnt !== 0) begin failures++; $display("FAIL exact_stats sum=%0d max=%0d cnt=%0d required 0 0 0", sum_ed, max_ed, err_cnt); end
      wait_done(cyc);
   endtask

   task automatic test_mixed;
      int cyc;
      va = '{8'd15, 8'd255, 8'd16, 8'd0};
      vb = '{8'd15, 8'd255, 8'd16, 8'd7};
      vr = '{16'd225, 16'd65000, 16'd250, 16'd3};
      send4(1'b0);
      @(negedge clk); @(negedge clk);
      checks++; if (sum_ed !== 34 || max_ed !== 25 || err_cnt !== 3) begin failures++; $display("FAIL mixed_stats sum=%0d max=%0d cnt=%0d required 34 25 3", sum_ed, max_ed, err_cnt); end
`ifdef ERR_SQ_EN
      checks++; if (sum_sq !== 670) begin failures++; $display("FAIL mixed_sq sum_sq=%0d required 670", sum_sq); end
`else
      checks++; if (sum_sq !== 0) begin failures++; $display("FAIL mixed_sq sum_sq=%0d required 0", sum_sq); end
`endif
      wait_done(cyc);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL mixed_done_latency cycles=%0d required 1", cyc); end
      repeat (3) @(negedge clk);
      checks++; if (done !== 1'b1 || sum_ed !== 34) begin failures++; $display("FAIL mixed_hold done=%b sum=%0d required 1 34", done, sum_ed); end
   endtask

   task automatic test_overestimate;
      int cyc;
      for (int i = 0; i < 4; i++) begin va[i] = 8'd3; vb[i] = 8'd3; vr[i] = 16'd12; end
      send4(1'b0);
      wait_done(cyc);
      checks++; if (cyc !== 3) begin failures++; $display("FAIL over_done_latency cycles=%0d required 3", cyc); end
      checks++; if (sum_ed !== 12 || max_ed !== 3 || err_cnt !== 4) begin failures++; $display("FAIL over_stats sum=%0d max=%0d cnt=%0d required 12 3 4", sum_ed, max_ed, err_cnt); end
   endtask

   task automatic test_backpressure;
      int xfers = 0;
      int cyc;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         if (i < 4) begin A = 8'd3; B = 8'd3; R = 16'd9; end
         else       begin A = 8'd255; B = 8'd255; R = 16'd0; end
         if (i == 4) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_after_4th in_ready=%b required 0", in_ready); end
         end
         if (in_valid && in_ready) xfers++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++; if (xfers !== 4) begin failures++; $display("FAIL bp_transfers count=%0d required 4", xfers); end
      wait_done(cyc);
      checks++; if (done !== 1'b1 || sum_ed !== 0 || max_ed !== 0 || err_cnt !== 0) begin failures++; $display("FAIL bp_stats done=%b sum=%0d max=%0d cnt=%0d required 1 0 0 0", done, sum_ed, max_ed, err_cnt); end
   endtask

   task automatic test_start_clear;
      int cyc;
      // Start in RUN after 2 samples must be ignored.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      A = 8'd3; B = 8'd3; R = 16'd12;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         start = (i == 2);
         @(negedge clk);
      end
      start = 1'b0; in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL run_start_ignored in_ready=%b busy=%b required 0 1", in_ready, busy); end
      wait_done(cyc);
      checks++; if (done !== 1'b1 || sum_ed !== 12 || err_cnt !== 4) begin failures++; $display("FAIL run_start_stats done=%b sum=%0d cnt=%0d required 1 12 4", done, sum_ed, err_cnt); end
      // Start from DONE clears; a junk sample on the start edge must be dropped.
      @(negedge clk); start = 1'b1; in_valid = 1'b1; A = 8'd255; B = 8'd255; R = 16'd0;
      @(negedge clk); start = 1'b0; in_valid = 1'b0;
      checks++; if (sum_ed !== 0 || max_ed !== 0 || err_cnt !== 0 || done !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL done_clear sum=%0d max=%0d cnt=%0d done=%b in_ready=%b required 0 0 0 0 1", sum_ed, max_ed, err_cnt, done, in_ready); end
      @(negedge clk); @(negedge clk);
      checks++; if (sum_ed !== 0 || err_cnt !== 0) begin failures++; $display("FAIL start_edge_dropped sum=%0d cnt=%0d required 0 0", sum_ed, err_cnt); end
      A = 8'd2; B = 8'd2; R = 16'd4;
      for (int i = 0; i < 4; i++) begin in_valid = 1'b1; @(negedge clk); end
      in_valid = 1'b0;
      wait_done(cyc);
      checks++; if (cyc !== 3 || sum_ed !== 0 || err_cnt !== 0) begin failures++; $display("FAIL after_clear cycles=%0d sum=%0d cnt=%0d required 3 0 0", cyc, sum_ed, err_cnt); end
   endtask

   task automatic test_async_reset;
      int cyc;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      A = 8'd3; B = 8'd3; R = 16'd12;
      for (int i = 0; i < 3; i++) begin in_valid = 1'b1; @(negedge clk); end
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (sum_ed !== 6 || busy !== 1'b1) begin failures++; $display("FAIL partial_sum sum=%0d busy=%b required 6 1", sum_ed, busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (done !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || sum_ed !== 0 || err_cnt !== 0) begin failures++; $display("FAIL mid_reset done=%b in_ready=%b busy=%b sum=%0d cnt=%0d required 0 0 0 0 0", done, in_ready, busy, sum_ed, err_cnt); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_idle in_ready=%b busy=%b required 0 0", in_ready, busy); end
      va = '{8'd15, 8'd255, 8'd16, 8'd0};
      vb = '{8'd15, 8'd255, 8'd16, 8'd7};
      vr = '{16'd225, 16'd65000, 16'd250, 16'd3};
      send4(1'b1);
      wait_done(cyc);
      checks++; if (cyc !== 3 || sum_ed !== 34 || max_ed !== 25 || err_cnt !== 3) begin failures++; $display("FAIL post_reset cycles=%0d sum=%0d max=%0d cnt=%0d required 3 34 25 3", cyc, sum_ed, max_ed, err_cnt); end
   endtask

   initial begin
      test_reset();
      test_exact();
      test_mixed();
      test_overestimate();
      test_backpressure();
      test_start_clear();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout sim time exceeded");
      $fatal(1);
   end
endmodule
